// File: rtl/dm_cache_ctrl_if.sv
// CPU, data-memory and backing-memory signals of the direct-mapped cache controller.
// The DM_CACHE_STATS_EN macro adds the hit/miss counter outputs.
interface dm_cache_ctrl_if #(parameter int MEM_DEPTH = 8);
  logic                 i_req;
  logic                 o_ready;
  logic                 i_we;
  logic [31:0]          i_addr;
  logic [31:0]          i_wdata;
  logic                 o_resp_valid;
  logic [31:0]          o_resp_data;
  logic                 i_flush;
  logic                 o_cm_write;
  logic [MEM_DEPTH-1:0] o_cm_addr;
  logic [31:0]          o_cm_wdata;
  logic [31:0]          i_cm_rdata;
  logic                 o_mem_req;
  logic                 o_mem_we;
  logic [31:0]          o_mem_addr;
  logic [31:0]          o_mem_wdata;
  logic                 i_mem_ack;
  logic [31:0]          i_mem_rdata;
`ifdef DM_CACHE_STATS_EN
  logic [31:0]          o_hit_cnt;
  logic [31:0]          o_miss_cnt;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_flush, i_cm_rdata, i_mem_ack, i_mem_rdata,
    input  o_ready, o_resp_valid, o_resp_data, o_cm_write, o_cm_addr, o_cm_wdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_hit_cnt, o_miss_cnt
  );
  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_flush, i_cm_rdata, i_mem_ack, i_mem_rdata,
    output o_ready, o_resp_valid, o_resp_data, o_cm_write, o_cm_addr, o_cm_wdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_hit_cnt, o_miss_cnt
  );
`else
  modport master (
    output i_req, i_we, i_addr, i_wdata, i_flush, i_cm_rdata, i_mem_ack, i_mem_rdata,
    input  o_ready, o_resp_valid, o_resp_data, o_cm_write, o_cm_addr, o_cm_wdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );
  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_flush, i_cm_rdata, i_mem_ack, i_mem_rdata,
    output o_ready, o_resp_valid, o_resp_data, o_cm_write, o_cm_addr, o_cm_wdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );
`endif
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller (one word per line).
// Define DM_CACHE_STATS_EN to add the hit/miss lookup counters.
module dm_cache_ctrl #(
  parameter int MEM_DEPTH = 8
) (
  input logic            i_clk,
  input logic            i_reset,
  dm_cache_ctrl_if.slave bus
);
  localparam int TAG_W = 30 - MEM_DEPTH;

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, MEM_RD = 2'd2, MEM_WR = 2'd3} state_t;

  state_t                 state_r;
  logic [(1<<MEM_DEPTH)-1:0] valid_r;
  logic [TAG_W-1:0]       tag_mem_r [(1<<MEM_DEPTH)];
  logic [29:0]            addr_r;
  logic                   we_r;
  logic [31:0]            wdata_r;
  logic                   mem_req_r;
  logic                   mem_we_r;
  logic [31:0]            mem_addr_r;
  logic [31:0]            mem_wdata_r;

  logic [MEM_DEPTH-1:0]   idx_s;
  logic [TAG_W-1:0]       tag_s;
  logic                   hit_s;
  logic                   ack_s;
  logic                   ready_s;
  logic                   resp_valid_s;
  logic [31:0]            resp_data_s;
  logic                   cm_write_s;
  logic [MEM_DEPTH-1:0]   cm_addr_s;
  logic [31:0]            cm_wdata_s;

  assign idx_s = addr_r[MEM_DEPTH-1:0];
  assign tag_s = addr_r[29:MEM_DEPTH];
  assign hit_s = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
  // An ack only counts while a backing-memory request is actually outstanding.
  assign ack_s = bus.i_mem_ack && mem_req_r;

  // Data-memory drive and CPU response, decoded from the current state.
  always_comb begin
    ready_s      = (state_r == IDLE) && !bus.i_flush && !i_reset;
    resp_valid_s = 1'b0;
    resp_data_s  = 32'h0;
    cm_write_s   = 1'b0;
    cm_addr_s    = idx_s;
    cm_wdata_s   = 32'h0;
    case (state_r)
      IDLE: begin
        if (i_reset) begin
          cm_addr_s = '0;
        end else begin
          cm_addr_s = bus.i_addr[MEM_DEPTH+1:2];
        end
      end
      LOOKUP: begin
        if (hit_s && we_r) begin
          cm_write_s = 1'b1;
          cm_wdata_s = wdata_r;
        end else if (hit_s) begin
          resp_valid_s = 1'b1;
          resp_data_s  = bus.i_cm_rdata;
        end else begin
          resp_valid_s = 1'b0;
        end
      end
      MEM_RD: begin
        if (ack_s) begin
          cm_write_s   = 1'b1;
          cm_wdata_s   = bus.i_mem_rdata;
          resp_valid_s = 1'b1;
          resp_data_s  = bus.i_mem_rdata;
        end else begin
          resp_valid_s = 1'b0;
        end
      end
      MEM_WR: begin
        if (ack_s) begin
          resp_valid_s = 1'b1;
        end else begin
          resp_valid_s = 1'b0;
        end
      end
      default: begin
        cm_addr_s = '0;
      end
    endcase
  end

  // Controller FSM: request capture, valid bits and the backing-memory request registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      addr_r      <= 30'h0;
      we_r        <= 1'b0;
      wdata_r     <= 32'h0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0;
      mem_wdata_r <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.i_flush) begin
            valid_r <= '0;
          end else if (bus.i_req) begin
            addr_r  <= bus.i_addr[31:2];
            we_r    <= bus.i_we;
            wdata_r <= bus.i_wdata;
            state_r <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!we_r && hit_s) begin
            state_r <= IDLE;
          end else begin
            // Write-through: every write goes to memory, hit or miss.
            state_r     <= we_r ? MEM_WR : MEM_RD;
            mem_req_r   <= 1'b1;
            mem_we_r    <= we_r;
            mem_addr_r  <= {addr_r, 2'b00};
            mem_wdata_r <= we_r ? wdata_r : 32'h0;
          end
        end
        MEM_RD, MEM_WR: begin
          if (ack_s) begin
            if (state_r == MEM_RD) begin
              valid_r[idx_s] <= 1'b1;
            end
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0;
            mem_wdata_r <= 32'h0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Tag array; only meaningful where the matching valid bit is set, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if ((state_r == MEM_RD) && ack_s) begin
      tag_mem_r[idx_s] <= tag_s;
    end
  end

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  // Lookup statistics; deliberately untouched by flush.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hit_cnt_r  <= 32'h0;
      miss_cnt_r <= 32'h0;
    end else if (state_r == LOOKUP) begin
      if (hit_s) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end else begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign bus.o_hit_cnt  = hit_cnt_r;
  assign bus.o_miss_cnt = miss_cnt_r;
`endif

  assign bus.o_ready      = ready_s;
  assign bus.o_resp_valid = resp_valid_s;
  assign bus.o_resp_data  = resp_data_s;
  assign bus.o_cm_write   = cm_write_s;
  assign bus.o_cm_addr    = cm_addr_s;
  assign bus.o_cm_wdata   = cm_wdata_s;
  assign bus.o_mem_req    = mem_req_r;
  assign bus.o_mem_we     = mem_we_r;
  assign bus.o_mem_addr   = mem_addr_r;
  assign bus.o_mem_wdata  = mem_wdata_r;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with a data-memory model and a latency-controlled backing memory.
module tb_dm_cache_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  dm_cache_ctrl_if #(.MEM_DEPTH(8)) bus ();
  dm_cache_ctrl #(.MEM_DEPTH(8)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  logic [31:0] cm_mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: writes in the clock-low phase, combinational read.
  always @(negedge clk) begin
    if (bus.o_cm_write) cm_mem[bus.o_cm_addr] <= bus.o_cm_wdata;
  end
  assign bus.i_cm_rdata = cm_mem[bus.o_cm_addr];

  // Observations of the last transaction.
  logic [31:0] rd, cmw_data, ma, mwd;
  logic [7:0]  cmw_idx;
  logic        mwe, mreq_after, tmo;
  int          lat_c, n_memreq, n_cmw;

  // Issue one request, ack the backing memory after 'lat' request cycles, record what was seen.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] mdata, input int lat);
    int wait_c;
    rd = 32'h0; lat_c = 0; n_memreq = 0; n_cmw = 0; cmw_idx = 8'h0; cmw_data = 32'h0;
    ma = 32'h0; mwe = 1'b0; mwd = 32'h0; mreq_after = 1'b1; tmo = 1'b1; wait_c = 0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wdata;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.i_req = 1'b0;
      if (bus.o_mem_req) begin
        n_memreq++; ma = bus.o_mem_addr; mwe = bus.o_mem_we; mwd = bus.o_mem_wdata;
        wait_c++;
        if (wait_c == lat) begin
          bus.i_mem_ack = 1'b1; bus.i_mem_rdata = mdata;
        end
      end
      #1;
      if (bus.o_cm_write) begin
        n_cmw++; cmw_idx = bus.o_cm_addr; cmw_data = bus.o_cm_wdata;
      end
      if (bus.o_resp_valid) begin
        rd = bus.o_resp_data; lat_c = k; tmo = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = 32'h0;
    mreq_after = bus.o_mem_req;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_in_reset got %b exp 0", bus.o_ready); end
    n_cmp++; if (bus.o_cm_addr !== 8'h00) begin n_bad++; $display("FAIL rst_cm_addr got %h exp 00", bus.o_cm_addr); end
    n_cmp++; if ({bus.o_mem_req, bus.o_resp_valid, bus.o_cm_write} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes got %b exp 000", {bus.o_mem_req, bus.o_resp_valid, bus.o_cm_write}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after got %b exp 1", bus.o_ready); end
  endtask

  task automatic test_read_fill();
    xact(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL fill_timeout got %b exp 0", tmo); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fill_rdata got %h exp deadbeef", rd); end
    n_cmp++; if (ma !== 32'h0000_0010 || mwe !== 1'b0) begin n_bad++; $display("FAIL fill_mem_addr got %h/%b exp 00000010/0", ma, mwe); end
    n_cmp++; if (n_memreq !== 3 || lat_c !== 4) begin n_bad++; $display("FAIL fill_timing got req=%0d lat=%0d exp 3/4", n_memreq, lat_c); end
    n_cmp++; if (n_cmw !== 1 || cmw_idx !== 8'd4 || cmw_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fill_cm_write got n=%0d idx=%0d d=%h exp 1/4/deadbeef", n_cmw, cmw_idx, cmw_data); end
    n_cmp++; if (mreq_after !== 1'b0) begin n_bad++; $display("FAIL fill_req_drop got %b exp 0", mreq_after); end
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h5555_5555, 1);
    n_cmp++; if (rd !== 32'hDEAD_BEEF || lat_c !== 1) begin n_bad++; $display("FAIL hit_rdata got %h lat=%0d exp deadbeef/1", rd, lat_c); end
    n_cmp++; if (n_memreq !== 0 || n_cmw !== 0) begin n_bad++; $display("FAIL hit_no_mem got req=%0d cmw=%0d exp 0/0", n_memreq, n_cmw); end
  endtask

  task automatic test_write_hit();
    xact(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 2);
    n_cmp++; if (n_cmw !== 1 || cmw_idx !== 8'd4 || cmw_data !== 32'h1234_5678) begin n_bad++; $display("FAIL wh_cm_write got n=%0d idx=%0d d=%h exp 1/4/12345678", n_cmw, cmw_idx, cmw_data); end
    n_cmp++; if (mwe !== 1'b1 || mwd !== 32'h1234_5678 || ma !== 32'h10) begin n_bad++; $display("FAIL wh_mem got we=%b d=%h a=%h exp 1/12345678/10", mwe, mwd, ma); end
    n_cmp++; if (tmo !== 1'b0 || rd !== 32'h0 || lat_c !== 3) begin n_bad++; $display("FAIL wh_resp got tmo=%b d=%h lat=%0d exp 0/0/3", tmo, rd, lat_c); end
    xact(1'b0, 32'h0000_0010, 32'h0, 32'hFFFF_FFFF, 1);
    n_cmp++; if (rd !== 32'h1234_5678 || n_memreq !== 0) begin n_bad++; $display("FAIL wh_readback got %h req=%0d exp 12345678/0", rd, n_memreq); end
  endtask

  task automatic test_write_miss();
    xact(1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'h0, 1);
    n_cmp++; if (n_cmw !== 0) begin n_bad++; $display("FAIL wm_no_cm_write got %0d exp 0", n_cmw); end
    n_cmp++; if (n_memreq !== 1 || mwe !== 1'b1 || mwd !== 32'hAAAA_5555 || ma !== 32'h20) begin n_bad++; $display("FAIL wm_mem got req=%0d we=%b d=%h a=%h exp 1/1/aaaa5555/20", n_memreq, mwe, mwd, ma); end
    xact(1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 1);
    n_cmp++; if (n_memreq !== 1 || rd !== 32'h0BAD_F00D || cmw_idx !== 8'd8) begin n_bad++; $display("FAIL wm_read_miss got req=%0d d=%h idx=%0d exp 1/0badf00d/8", n_memreq, rd, cmw_idx); end
  endtask

  task automatic test_conflict();
    xact(1'b0, 32'h0000_0410, 32'h0, 32'h4104_1041, 2);
    n_cmp++; if (n_memreq !== 2 || ma !== 32'h410 || rd !== 32'h4104_1041 || cmw_idx !== 8'd4) begin n_bad++; $display("FAIL cf_evict got req=%0d a=%h d=%h idx=%0d exp 2/410/41041041/4", n_memreq, ma, rd, cmw_idx); end
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1);
    n_cmp++; if (n_memreq !== 1 || ma !== 32'h10 || rd !== 32'h1234_5678) begin n_bad++; $display("FAIL cf_remiss got req=%0d a=%h d=%h exp 1/10/12345678", n_memreq, ma, rd); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.i_flush = 1'b1; bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'h10;
    #1;
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_bad++; $display("FAIL fl_ready got %b exp 0", bus.o_ready); end
    @(negedge clk);
    bus.i_flush = 1'b0; bus.i_req = 1'b0;
    #1;
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL fl_not_accepted got ready=%b exp 1", bus.o_ready); end
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h0F0F_0F0F, 1);
    n_cmp++; if (n_memreq !== 1 || rd !== 32'h0F0F_0F0F) begin n_bad++; $display("FAIL fl_miss got req=%0d d=%h exp 1/0f0f0f0f", n_memreq, rd); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'h30;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.i_req = 1'b0;
      if (bus.o_mem_req) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rm_mem_req got %b exp 1", seen); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_mem_req !== 1'b0 || bus.o_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_drop got req=%b resp=%b exp 0/0", bus.o_mem_req, bus.o_resp_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.o_ready !== 1'b1 || bus.o_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_idle got ready=%b resp=%b exp 1/0", bus.o_ready, bus.o_resp_valid); end
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h7777_0010, 1);
    n_cmp++; if (n_memreq !== 1 || rd !== 32'h7777_0010) begin n_bad++; $display("FAIL rm_inv10 got req=%0d d=%h exp 1/77770010", n_memreq, rd); end
    xact(1'b0, 32'h0000_0020, 32'h0, 32'h7777_0020, 1);
    n_cmp++; if (n_memreq !== 1 || rd !== 32'h7777_0020) begin n_bad++; $display("FAIL rm_inv20 got req=%0d d=%h exp 1/77770020", n_memreq, rd); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 256; i++) cm_mem[i] = 32'h0;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0;
    bus.i_flush = 1'b0; bus.i_mem_ack = 1'b0; bus.i_mem_rdata = 32'h0;
    test_reset();
    test_read_fill();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
